iob_eth_rx_deframer: RTL

MII receive deframer for the iob_eth core, clocked directly by the PHY receive clock. Consumes the raw 4-bit MII nibble stream and detects preamble/SFD. Assembles bytes low-nibble-first and writes every post-SFD byte (destination MAC through FCS) into the receive buffer. Checks destination address, length and CRC-32, then reports a one-cycle frame-complete status to the receive control logic.

---
 rtl/iob_eth_rx_deframer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/iob_eth_rx_deframer.sv
// iob_eth_rx_deframer: MII receive deframer for the iob_eth core.
// Detects preamble/SFD on the RX_CLK nibble stream, assembles bytes
// low-nibble-first, writes them to the receive buffer and reports a
// one-cycle frame status (address filter, length, alignment, rx_er, CRC).
// Optional CRC-32 residue checking is compiled in when IOB_ETH_RX_CRC_EN
// is defined; without it only runt frames raise the crc status bit.

module iob_eth_rx_deframer #(
  parameter int BUF_ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            rx_data,
  input  logic                  rx_dv,
  input  logic                  rx_er,
  input  logic [47:0]           mac_addr,
  input  logic                  promisc,
  input  logic                  buf_busy,
  output logic                  buf_wr_en,
  output logic [BUF_ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]            buf_wr_data,
  output logic                  frame_done,
  output logic [BUF_ADDR_W:0]   frame_len,
  output logic [4:0]            frame_err,
  output logic                  frame_ok,
  output logic [15:0]           drop_cnt
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [BUF_ADDR_W:0] ADDR_BYTES = (BUF_ADDR_W+1)'(6);
  localparam logic [BUF_ADDR_W:0] RUNT_BYTES = (BUF_ADDR_W+1)'(10);
  localparam logic [BUF_ADDR_W:0] CNT_ONE    = (BUF_ADDR_W+1)'(1);

  state_t                state_q, state_d;
  logic                  rx_dv_q;
  logic                  phase_q;
  logic [3:0]            low_q;
  logic [BUF_ADDR_W:0]   byte_cnt_q;
  logic                  ucast_q, bcast_q, rx_er_q, ovf_q;
  logic                  sfd_hit, sfd_busy, byte_stb, frame_end;
  logic [7:0]            cur_byte, mac_byte;
  logic                  addr_field, crc_bad;
  logic [4:0]            err_vec;

  assign cur_byte   = {rx_data, low_q};
  assign addr_field = byte_cnt_q < ADDR_BYTES;

`ifdef IOB_ETH_RX_CRC_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  logic [31:0] crc_q;

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Running reflected CRC over every byte after SFD, including the FCS
  always_ff @(posedge clk) begin
    if (!rst_n)        crc_q <= '1;
    else if (sfd_hit)  crc_q <= '1;
    else if (byte_stb) crc_q <= crc_next(crc_q, cur_byte);
  end

  assign crc_bad = (crc_q != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // Final status: short frames fail the address and CRC checks outright
  assign err_vec = {(byte_cnt_q < ADDR_BYTES) | (~promisc & ~(ucast_q | bcast_q)),
                    phase_q, rx_er_q, ovf_q,
                    (byte_cnt_q < RUNT_BYTES) | crc_bad};

  // Station address byte that the current destination byte is compared with
  always_comb begin
    mac_byte = 8'h00;
    case (byte_cnt_q[2:0])
      3'd0:    mac_byte = mac_addr[47:40];
      3'd1:    mac_byte = mac_addr[39:32];
      3'd2:    mac_byte = mac_addr[31:24];
      3'd3:    mac_byte = mac_addr[23:16];
      3'd4:    mac_byte = mac_addr[15:8];
      3'd5:    mac_byte = mac_addr[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_d   = state_q;
    sfd_hit   = 1'b0;
    sfd_busy  = 1'b0;
    byte_stb  = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_dv && !rx_dv_q) state_d = (rx_data == 4'h5) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rx_data == 4'hD) begin
          if (buf_busy) begin
            sfd_busy = 1'b1;
            state_d  = DROP;
          end else begin
            sfd_hit = 1'b1;
            state_d = DATA;
          end
        end else if (rx_data != 4'h5) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!rx_dv) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end else if (phase_q) begin
          byte_stb = 1'b1;
        end
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // rx_dv history keeps running through reset so a frame in progress is never mistaken for a new one
  always_ff @(posedge clk) begin
    rx_dv_q <= rx_dv;
  end

  // Byte assembly, buffer writes, address filter, error flags and frame status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= 1'b0;
      low_q       <= 4'h0;
      byte_cnt_q  <= '0;
      ucast_q     <= 1'b0;
      bcast_q     <= 1'b0;
      rx_er_q     <= 1'b0;
      ovf_q       <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= 8'h00;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      frame_err   <= 5'h00;
      frame_ok    <= 1'b0;
      drop_cnt    <= 16'h0000;
    end else begin
      buf_wr_en  <= 1'b0;
      frame_done <= 1'b0;
      if (sfd_hit) begin
        phase_q    <= 1'b0;
        byte_cnt_q <= '0;
        ucast_q    <= 1'b1;
        bcast_q    <= 1'b1;
        rx_er_q    <= 1'b0;
        ovf_q      <= 1'b0;
      end
      if (sfd_busy && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (state_q == DATA && rx_dv) begin
        phase_q <= ~phase_q;
        if (!phase_q) low_q <= rx_data;
        if (rx_er) rx_er_q <= 1'b1;
      end
      if (byte_stb) begin
        if (!byte_cnt_q[BUF_ADDR_W]) begin
          buf_wr_en   <= 1'b1;
          buf_wr_addr <= byte_cnt_q[BUF_ADDR_W-1:0];
          buf_wr_data <= cur_byte;
          byte_cnt_q  <= byte_cnt_q + CNT_ONE;
        end else begin
          ovf_q <= 1'b1;
        end
        if (addr_field) begin
          ucast_q <= ucast_q & (cur_byte == mac_byte);
          bcast_q <= bcast_q & (cur_byte == 8'hFF);
        end
      end
      if (frame_end) begin
        frame_done <= 1'b1;
        frame_len  <= byte_cnt_q;
        frame_err  <= err_vec;
        frame_ok   <= (err_vec == 5'h00);
      end
    end
  end

endmodule
